// File: rtl/memory_arbiter_if.sv
// Cache-side and memory-side signal bundle for memory_arbiter.
// The arbiter uses the slave view; the caches and memory model use the master view.
interface memory_arbiter_if #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 20
);
  logic                  i_miss;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_fill_data;
  logic                  i_fill_valid;

  logic                  d_miss;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_fill_data;
  logic                  d_fill_valid;
  logic                  d_write_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic                  busy;
  logic                  grant_d;

  modport slave (
    input  i_miss, i_address, d_miss, d_write, d_address, d_wdata, mem_rdata, mem_ready,
    output i_fill_data, i_fill_valid, d_fill_data, d_fill_valid, d_write_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

  modport master (
    output i_miss, i_address, d_miss, d_write, d_address, d_wdata, mem_rdata, mem_ready,
    input  i_fill_data, i_fill_valid, d_fill_data, d_fill_valid, d_write_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy, grant_d
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One transaction at a time: IDLE (arbitrate) -> MEM (req/ready) -> RESP (one-cycle pulse).
module memory_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 20
) (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_last_d, w_last_d_next;
  logic                  r_owner_d, w_owner_d_next;
  logic                  r_we, w_we_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [LINE_WIDTH-1:0] r_wdata, w_wdata_next;
  logic                  r_req, w_req_next;
  logic [LINE_WIDTH-1:0] r_i_fill, w_i_fill_next;
  logic [LINE_WIDTH-1:0] r_d_fill, w_d_fill_next;
  logic                  r_i_vld, w_i_vld_next;
  logic                  r_d_vld, w_d_vld_next;
  logic                  r_wdone, w_wdone_next;
  logic                  r_busy;

  logic w_cand_i, w_cand_d, w_pick_d;

  assign w_cand_i = bus.i_miss;
  assign w_cand_d = bus.d_write | bus.d_miss;
  // On a tie the D-cache wins unless it owned the previous transaction.
  assign w_pick_d = w_cand_d & (~w_cand_i | ~r_last_d);

  always_comb begin
    w_state_next   = r_state;
    w_last_d_next  = r_last_d;
    w_owner_d_next = r_owner_d;
    w_we_next      = r_we;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_req_next     = 1'b0;
    w_i_fill_next  = r_i_fill;
    w_d_fill_next  = r_d_fill;
    w_i_vld_next   = 1'b0;
    w_d_vld_next   = 1'b0;
    w_wdone_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_cand_i | w_cand_d) begin
          w_owner_d_next = w_pick_d;
          w_last_d_next  = w_pick_d;
          // d_write has priority over d_miss so a dirty line leaves before its replacement arrives.
          w_we_next      = w_pick_d & bus.d_write;
          w_addr_next    = w_pick_d ? bus.d_address : bus.i_address;
          w_wdata_next   = (w_pick_d & bus.d_write) ? bus.d_wdata : '0;
          w_req_next     = 1'b1;
          w_state_next   = MEM;
        end
      end
      MEM: begin
        w_req_next = 1'b1;
        if (bus.mem_ready) begin
          w_req_next   = 1'b0;
          w_state_next = RESP;
          if (!r_we) begin
            if (r_owner_d) w_d_fill_next = bus.mem_rdata;
            else           w_i_fill_next = bus.mem_rdata;
          end
          w_wdone_next = r_owner_d & r_we;
          w_d_vld_next = r_owner_d & ~r_we;
          w_i_vld_next = ~r_owner_d;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_req     <= 1'b0;
      r_i_fill  <= '0;
      r_d_fill  <= '0;
      r_i_vld   <= 1'b0;
      r_d_vld   <= 1'b0;
      r_wdone   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_last_d  <= w_last_d_next;
      r_owner_d <= w_owner_d_next;
      r_we      <= w_we_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_req     <= w_req_next;
      r_i_fill  <= w_i_fill_next;
      r_d_fill  <= w_d_fill_next;
      r_i_vld   <= w_i_vld_next;
      r_d_vld   <= w_d_vld_next;
      r_wdone   <= w_wdone_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  assign bus.mem_req      = r_req;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.i_fill_data  = r_i_fill;
  assign bus.i_fill_valid = r_i_vld;
  assign bus.d_fill_data  = r_d_fill;
  assign bus.d_fill_valid = r_d_vld;
  assign bus.d_write_done = r_wdone;
  assign bus.busy         = r_busy;
  assign bus.grant_d      = r_owner_d;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: a latency-programmable memory model, a bus monitor
// and a requester loop that drops each request in the cycle after its response pulse.
module tb_memory_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_arbiter_if #(.LINE_WIDTH(128), .ADDR_WIDTH(20)) bus ();

  memory_arbiter #(.LINE_WIDTH(128), .ADDR_WIDTH(20)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [19:0] a);
    return {32'hDEADBEEF, 56'h0, a, 20'h00001};
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: mem_ready in the lat-th cycle of mem_req; spur forces a stray pulse.
  int   lat  = 1;
  logic spur = 1'b0;
  int   mcnt = 0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (reset || !bus.mem_req) begin
        mcnt = 0;
        bus.mem_ready = spur;
      end else begin
        mcnt++;
        bus.mem_ready = (mcnt == lat);
        if (mcnt == lat) bus.mem_rdata = pat(bus.mem_addr);
      end
    end
  end

  // Bus monitor: logs transactions and response pulses, checks stability and pulse timing.
  int            ord_log [8];
  int            n_ord = 0;
  logic          tx_we   [8];
  logic [19:0]   tx_addr [8];
  logic [127:0]  tx_wdata[8];
  int            tx_cyc  [8];
  int            n_tx = 0;
  int            ready_cyc = -10;
  logic          prev_req = 1'b0;
  logic [2:0]    prev_pulses = 3'b000;
  logic          held_we;
  logic [19:0]   held_addr;
  logic [127:0]  held_wdata;

  initial begin
    logic [2:0] pulses;
    int code;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_req = 1'b0;
        prev_pulses = 3'b000;
        continue;
      end
      if (bus.mem_req && !prev_req) begin
        held_we = bus.mem_we; held_addr = bus.mem_addr; held_wdata = bus.mem_wdata;
        if (n_tx < 8) begin
          tx_we[n_tx] = bus.mem_we; tx_addr[n_tx] = bus.mem_addr;
          tx_wdata[n_tx] = bus.mem_wdata; tx_cyc[n_tx] = cyc;
        end
        n_tx++;
      end else if (bus.mem_req) begin
        check("stable_we", bus.mem_we, held_we);
        check("stable_addr", bus.mem_addr, held_addr);
        check("stable_wdata", bus.mem_wdata, held_wdata);
      end
      if (bus.mem_req) check("req_implies_busy", bus.busy, 1'b1);
      if (bus.mem_req && bus.mem_ready) ready_cyc = cyc;
      if (cyc == ready_cyc + 1) begin
        check("resp_busy", bus.busy, 1'b1);
        check("resp_req_low", bus.mem_req, 1'b0);
      end
      if (cyc == ready_cyc + 2) check("idle_busy_low", bus.busy, 1'b0);
      pulses = {bus.i_fill_valid, bus.d_fill_valid, bus.d_write_done};
      if (pulses != 3'b000) begin
        check("one_pulse", ($countones(pulses) == 1), 1'b1);
        check("pulse_width", prev_pulses, 3'b000);
        check("pulse_latency", cyc, ready_cyc + 1);
        code = bus.i_fill_valid ? 1 : (bus.d_fill_valid ? 2 : 3);
        if (n_ord < 8) ord_log[n_ord] = code;
        n_ord++;
        $display("txn cycle=%0d kind=%s grant_d=%0b i_data=%h d_data=%h", cyc,
                 (code == 1) ? "I_FILL" : ((code == 2) ? "D_FILL" : "D_WB_DONE"),
                 bus.grant_d, bus.i_fill_data, bus.d_fill_data);
      end
      prev_pulses = pulses;
      prev_req = bus.mem_req;
    end
  end

  logic [19:0] d_fill_addr = '0;
  int          req_cyc;

  task automatic clear_log();
    n_ord = 0;
    n_tx  = 0;
    for (int k = 0; k < 8; k++) begin
      ord_log[k] = -1; tx_we[k] = 1'bx; tx_addr[k] = 'x; tx_wdata[k] = 'x; tx_cyc[k] = -1;
    end
  endtask

  // Requester behaviour: hold requests until serviced, drop them the cycle after the pulse.
  task automatic serve(input string tag, input int maxcyc);
    int n = 0;
    while ((bus.i_miss || bus.d_miss || bus.d_write || bus.busy) && n < maxcyc) begin
      @(posedge clock); #3;
      if (bus.i_fill_valid) bus.i_miss = 1'b0;
      if (bus.d_fill_valid) bus.d_miss = 1'b0;
      if (bus.d_write_done) begin
        bus.d_write = 1'b0;
        bus.d_address = d_fill_addr;
      end
      n++;
    end
    check({tag, "_serve_bound"}, (n < maxcyc), 1'b1);
  endtask

  task automatic wait_req(input string tag, input int maxcyc);
    int n = 0;
    while (!bus.mem_req && n < maxcyc) begin
      @(posedge clock); #3;
      n++;
    end
    check({tag, "_req_seen"}, bus.mem_req, 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_miss = 1'b0; bus.i_address = '0;
    bus.d_miss = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    clear_log();
    repeat (3) @(posedge clock);
    #3;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 20'h0);
    check("rst_grant_d", bus.grant_d, 1'b0);
    check("rst_pulses", {bus.i_fill_valid, bus.d_fill_valid, bus.d_write_done}, 3'b000);
    check("rst_fill_data", {bus.i_fill_data | bus.d_fill_data}, 128'h0);
    reset = 1'b0;
    @(posedge clock); #3;
    check("idle_busy", bus.busy, 1'b0);

    // Single I miss, 4-cycle memory.
    clear_log();
    lat = 4;
    bus.i_address = 20'h00040;
    bus.i_miss = 1'b1;
    req_cyc = cyc;
    serve("t1", 40);
    check("t1_n_pulses", n_ord, 1);
    check("t1_kind", ord_log[0], 1);
    check("t1_we", tx_we[0], 1'b0);
    check("t1_addr", tx_addr[0], 20'h00040);
    check("t1_req_latency", tx_cyc[0], req_cyc + 1);
    check("t1_i_data", bus.i_fill_data, pat(20'h00040));
    check("t1_grant_d", bus.grant_d, 1'b0);

    // D writeback.
    clear_log();
    lat = 2;
    bus.d_address = 20'h01230;
    d_fill_addr = 20'h01230;
    bus.d_wdata = {4{32'hA5A5A5A5}};
    bus.d_write = 1'b1;
    serve("t2", 40);
    check("t2_n_pulses", n_ord, 1);
    check("t2_kind", ord_log[0], 3);
    check("t2_we", tx_we[0], 1'b1);
    check("t2_addr", tx_addr[0], 20'h01230);
    check("t2_wdata", tx_wdata[0], {4{32'hA5A5A5A5}});
    check("t2_grant_d", bus.grant_d, 1'b1);
    check("t2_d_data_untouched", bus.d_fill_data, 128'h0);

    // Simultaneous misses after reset: D first, then I; repeat gives D first again.
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      clear_log();
      lat = 1;
      bus.i_address = (r == 0) ? 20'h00100 : 20'h00300;
      bus.d_address = (r == 0) ? 20'h00200 : 20'h00400;
      d_fill_addr = bus.d_address;
      bus.i_miss = 1'b1;
      bus.d_miss = 1'b1;
      serve("t3", 40);
      check("t3_n_pulses", n_ord, 2);
      check("t3_first", ord_log[0], 2);
      check("t3_second", ord_log[1], 1);
      check("t3_addr0", tx_addr[0], (r == 0) ? 20'h00200 : 20'h00400);
      check("t3_addr1", tx_addr[1], (r == 0) ? 20'h00100 : 20'h00300);
      check("t3_turnaround", tx_cyc[1], tx_cyc[0] + 3);
      check("t3_d_data", bus.d_fill_data, pat((r == 0) ? 20'h00200 : 20'h00400));
      check("t3_i_data", bus.i_fill_data, pat((r == 0) ? 20'h00100 : 20'h00300));
      check("t3_grant_d", bus.grant_d, 1'b0);
    end

    // Eviction + fill with an I miss waiting: D-write, I-fill, D-fill.
    clear_log();
    lat = 2;
    bus.d_address = 20'h03000;
    d_fill_addr = 20'h04000;
    bus.d_wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
    bus.i_address = 20'h05000;
    bus.d_write = 1'b1;
    bus.d_miss = 1'b1;
    bus.i_miss = 1'b1;
    serve("t4", 60);
    check("t4_n_pulses", n_ord, 3);
    check("t4_kind0", ord_log[0], 3);
    check("t4_kind1", ord_log[1], 1);
    check("t4_kind2", ord_log[2], 2);
    check("t4_addr0", tx_addr[0], 20'h03000);
    check("t4_we0", tx_we[0], 1'b1);
    check("t4_wdata0", tx_wdata[0], 128'h0123456789ABCDEF_FEDCBA9876543210);
    check("t4_addr1", tx_addr[1], 20'h05000);
    check("t4_addr2", tx_addr[2], 20'h04000);
    check("t4_we2", tx_we[2], 1'b0);
    check("t4_d_data", bus.d_fill_data, pat(20'h04000));
    check("t4_i_data", bus.i_fill_data, pat(20'h05000));

    // Spurious mem_ready in IDLE.
    clear_log();
    spur = 1'b1;
    @(posedge clock); #3;
    spur = 1'b0;
    @(posedge clock); #3;
    check("t5_spur_busy", bus.busy, 1'b0);
    check("t5_spur_req", bus.mem_req, 1'b0);
    @(posedge clock); #3;
    check("t5_spur_pulses", n_ord, 0);
    check("t5_spur_tx", n_tx, 0);

    // Address change during MEM must not reach mem_addr.
    lat = 6;
    bus.d_address = 20'h06000;
    d_fill_addr = 20'h06000;
    bus.d_miss = 1'b1;
    wait_req("t5", 10);
    bus.d_address = 20'h0FFFF;
    repeat (2) begin
      @(posedge clock); #3;
    end
    check("t5_mem_addr_held", bus.mem_addr, 20'h06000);
    check("t5_mem_we_held", bus.mem_we, 1'b0);
    serve("t5", 40);
    check("t5_kind", ord_log[0], 2);
    check("t5_d_data", bus.d_fill_data, pat(20'h06000));

    // Reset mid-MEM abandons the transaction; a later request is serviced normally.
    clear_log();
    lat = 8;
    bus.i_address = 20'h07000;
    bus.i_miss = 1'b1;
    wait_req("t6", 10);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("t6_rst_req", bus.mem_req, 1'b0);
    check("t6_rst_busy", bus.busy, 1'b0);
    check("t6_rst_pulses", {bus.i_fill_valid, bus.d_fill_valid, bus.d_write_done}, 3'b000);
    check("t6_rst_i_data", bus.i_fill_data, 128'h0);
    bus.i_miss = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    @(posedge clock); #3;
    check("t6_no_pulse", n_ord, 0);
    lat = 3;
    bus.d_address = 20'h08000;
    d_fill_addr = 20'h08000;
    bus.d_miss = 1'b1;
    serve("t6", 40);
    check("t6_n_pulses", n_ord, 1);
    check("t6_kind", ord_log[0], 2);
    check("t6_addr", tx_addr[1], 20'h08000);
    check("t6_d_data", bus.d_fill_data, pat(20'h08000));
    check("t6_i_data_clear", bus.i_fill_data, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
